// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the MIPS-style core: drives PC/IR/memory/regfile/ALU controls,
// counts retired instructions and traps on illegal opcodes or memory-port timeouts.
module multicycle_control_fsm #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_load,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_retired
);

    // state   | meaning
    // FETCH   | read instruction at PC, PC+4 | DECODE  | precompute branch target
    // MEM*    | lw/sw address, access, wb    | EXEC/ALUWB, ADDI_* | ALU ops and writeback
    // TRAP    | halted until reset
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;
    localparam logic [7:0] WAIT_LAST     = 8'(WAIT_LIMIT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        halted     = 1'b0;
        trap_cause = 2'b00;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_load   = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                halted     = 1'b1;
                trap_cause = cause_q;
            end
            default: begin
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase

        // a ready on the limit cycle completes the access, so only an unanswered limit cycle traps
        if (mem_req && !mem_ready && wait_q == WAIT_LAST) begin
            state_d = S_TRAP;
            cause_d = CAUSE_BUS;
        end

        wait_d    = (mem_req && !mem_ready && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            wait_q    <= 8'd0;
            cause_q   <= 2'b00;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign state         = state_q;
    assign instr_retired = retired_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle sequencer for the MIPS-style core. It replaces single-cycle decode with a Moore/Mealy FSM that drives PC update, IR load, the single shared memory port (instruction fetch and data access through one port with a ready handshake), register-file write and ALU operand/op selection. It sits between Program_Counter, the unified memory and the ALU/register datapath. It also provides a retired-instruction counter, a memory-wait watchdog and a sticky trap for illegal opcodes and bus timeouts.

Parameters:
WAIT_LIMIT, 16, maximum consecutive cycles mem_req may stay unanswered before bus-error trap (range 1..255)
CNT_W, 32, width of instr_retired counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe, valid with mem_req
iord  out  1  memory address select: 0 = PC, 1 = ALU result register
ir_load  out  1  load IR from memory read data
pc_write  out  1  PC load enable
pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
reg_write  out  1  register-file write enable
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
state  out  4  current state code (debug)
halted  out  1  sticky trap indicator
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout
instr_retired  out  CNT_W  count of completed instructions

Behaviour:
- State codes: RESET=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDI_EX=11, ADDI_WB=12, TRAP=13. Codes 14 and 15 are unused and go to TRAP with cause 01.
- rst_n low (async): state=RESET, wait counter=0, instr_retired=0, halted=0, trap_cause=00. Every output is 0 in RESET. The first rising edge after rst_n deasserts moves to FETCH. A reset mid-access abandons the access immediately, and mem_req drops asynchronously.
- Outputs are decoded from state. All outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_load=pc_write=mem_ready (Mealy). Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_b=11, alu_op=00. Next state by opcode: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX; any other opcode -> TRAP with cause 01.
- MEMADR: alu_src_a=1, alu_src_b=10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready, then goes to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write=zero. Goes to FETCH.
- JUMP: pc_src=10, pc_write=1. Goes to FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0. Goes to FETCH.
- Latency with zero-wait memory: beq and j take 3 cycles; R-type, addi and sw take 4; lw takes 5. Each memory wait cycle adds 1.
- Watchdog: the wait counter increments on each cycle with mem_req=1 and mem_ready=0, and clears when mem_ready=1 or the state changes. When the counter reaches WAIT_LIMIT with mem_ready still 0, the FSM goes to TRAP with cause 10. mem_ready=1 on the limit cycle wins: the access completes and no trap occurs.
- TRAP: all outputs 0 except halted=1, trap_cause held and state. Only rst_n exits TRAP.
- instr_retired increments by 1 on the clock edge leaving MEMWB, ALUWB, BRANCH, JUMP or ADDI_WB, or leaving MEMWR with mem_ready. It wraps modulo 2^CNT_W. It does not count trapped instructions.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- Reset, then R-type (opcode 000000), mem_ready tied 1 -> states 1,2,7,8,1; reg_write=1 and reg_dst=1 only in ALUWB; instr_retired=1 after 4 cycles.
- lw (100011) with mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_req=1 and iord=1 throughout, total 8 cycles, mem_to_reg=1 in MEMWB.
- beq with zero=1, then beq with zero=0 -> pc_write=1 with pc_src=01 in the first BRANCH state, pc_write=0 in the second; each instruction takes 3 cycles.
- Opcode 111111 in DECODE -> TRAP next cycle, halted=1, trap_cause=01, mem_req stays 0 for 20 cycles, instr_retired unchanged.
- WAIT_LIMIT=4 with mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, trap_cause=10. Repeat with mem_ready=1 on the 4th wait cycle -> no trap, FSM goes to DECODE.
- rst_n pulled low mid-MEMWR -> mem_req and mem_we drop without waiting for a clock edge, state=0, counter=0. After release, FSM enters FETCH on the next edge.
